sprite_hpos_gen: RTL

Parametrised horizontal scan-position generator for the sprite module. It runs on the system clock with a pixel-enable strobe, restarts on every h_sync rising edge, and counts blanking pixels up to the active window. Inside the window it publishes a LANES-wide group of consecutive column addresses plus lane index and group strobe. The sprite memory fetch logic uses these to read one tile row per group.

---
 rtl/sprite_hpos_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sprite_hpos_gen.sv
// sprite_hpos_gen: horizontal scan-position generator for the sprite fetch path.
// Restarts on each h_sync rising edge and counts H_START blanking pixels.
// Inside the active window it publishes a LANES-wide group of column
// addresses, the lane of the latest pixel and a one-cycle group strobe.
// Optional feature macro: VLINE_CNT_EN adds v_sync/v_line line counting.
module sprite_hpos_gen #(
    parameter int LANES    = 16,
    parameter int POS_W    = 10,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int VPOS_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_en,
    input  logic                       h_sync,
    output logic                       active,
    output logic [POS_W-1:0]           h_pos_base,
    output logic [LANES*POS_W-1:0]     h_pos_bus,
    output logic [$clog2(LANES)-1:0]   lane_idx,
    output logic                       tile_stb
`ifdef VLINE_CNT_EN
    ,
    input  logic                       v_sync,
    output logic [VPOS_W-1:0]          v_line
`endif
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [POS_W-1:0] START_C     = POS_W'(H_START);
    localparam logic [POS_W-1:0] ACTIVE_C    = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] LANE_MASK_C = POS_W'(LANES - 1);

    logic              h_sync_q;
    logic              hs_rise;
    logic [POS_W-1:0]  px_cnt_q, px_cnt_d;
    logic [POS_W-1:0]  base_q, base_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              active_q, active_d;
    logic              stb_q, stb_d;
    logic [POS_W-1:0]  k;

    assign hs_rise = h_sync & ~h_sync_q;
    assign k       = px_cnt_q - START_C;

    // Next-state for the line counter: restart beats pixel strobe, window end freezes.
    always_comb begin
        px_cnt_d = px_cnt_q;
        base_d   = base_q;
        lane_d   = lane_q;
        active_d = active_q;
        stb_d    = 1'b0;
        if (hs_rise) begin
            px_cnt_d = '0;
            base_d   = '0;
            lane_d   = '0;
            active_d = 1'b0;
        end else if (pix_en) begin
            if (px_cnt_q < START_C) begin
                px_cnt_d = px_cnt_q + 1'b1;
                active_d = 1'b0;
            end else if (k < ACTIVE_C) begin
                px_cnt_d = px_cnt_q + 1'b1;
                active_d = 1'b1;
                lane_d   = k[LANE_W-1:0];
                base_d   = k & ~LANE_MASK_C;
                stb_d    = (k[LANE_W-1:0] == '0);
            end else begin
                active_d = 1'b0;
            end
        end
    end

    // Register line state and the h_sync edge detector; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_sync_q <= 1'b0;
            px_cnt_q <= '0;
            base_q   <= '0;
            lane_q   <= '0;
            active_q <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            h_sync_q <= h_sync;
            px_cnt_q <= px_cnt_d;
            base_q   <= base_d;
            lane_q   <= lane_d;
            active_q <= active_d;
            stb_q    <= stb_d;
        end
    end

    assign active     = active_q;
    assign h_pos_base = base_q;
    assign lane_idx   = lane_q;
    assign tile_stb   = stb_q;

    // Each lane address is derived from the registered group base.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign h_pos_bus[gi*POS_W +: POS_W] = base_q + POS_W'(gi);
        end
    endgenerate

`ifdef VLINE_CNT_EN
    logic              v_sync_q;
    logic              vs_rise;
    logic [VPOS_W-1:0] v_line_q;

    assign vs_rise = v_sync & ~v_sync_q;

    // Count lines since the last v_sync edge; v_sync edge wins and the count saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v_sync_q <= 1'b0;
            v_line_q <= '0;
        end else begin
            v_sync_q <= v_sync;
            if (vs_rise) begin
                v_line_q <= '0;
            end else if (hs_rise && (v_line_q != '1)) begin
                v_line_q <= v_line_q + 1'b1;
            end
        end
    end

    assign v_line = v_line_q;
`endif

endmodule
